// File: rtl/ibex_pkg.sv
// rtl/ibex_pkg.sv - shared types for the iterative multiplier/divider
package ibex_pkg;

    // Operation class; the signedness comes from signed_mode separately.
    typedef enum logic [1:0] {
        MD_OP_MULL,
        MD_OP_MULH,
        MD_OP_DIV,
        MD_OP_REM
    } md_op_e;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIXUP,
        DONE
    } md_iter_state_e;

    // Largest number of bits retired per ITER cycle that the step slice supports.
    localparam int MD_ITER_MAX_RADIX = 4;

endpackage

// File: rtl/ibex_multdiv_iter_step.sv
// rtl/ibex_multdiv_iter_step.sv - combinational radix step for multiply and divide
//
// Ports:
//   is_div_i   : 1 selects the compare-subtract path, 0 the multiply-accumulate path
//   acc_i      : mult: running product; div: {remainder, dividend/quotient shift register}
//   mcand_i    : mult only: multiplicand already aligned to the current digit position
//   digit_i    : mult only: lowest RADIX_BITS of the remaining multiplier
//   divisor_i  : div only: divisor magnitude
//   acc_o      : updated accumulator after one radix step
module ibex_multdiv_iter_step #(
    parameter int WIDTH      = 32,
    parameter int RADIX_BITS = 1
) (
    input  logic                   is_div_i,
    input  logic [2*WIDTH-1:0]     acc_i,
    input  logic [2*WIDTH-1:0]     mcand_i,
    input  logic [RADIX_BITS-1:0]  digit_i,
    input  logic [WIDTH-1:0]       divisor_i,
    output logic [2*WIDTH-1:0]     acc_o
);

    logic [2*WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH:0]     trial;

    // Multiply: add mcand * digit as a sum of shifted multiplicands.
    always_comb begin
        mul_acc = acc_i;
        for (int j = 0; j < RADIX_BITS; j++) begin
            if (digit_i[j]) begin
                mul_acc = mul_acc + (mcand_i << j);
            end
        end
    end

    // Divide: restoring division, one quotient bit per sub-step, MSB first.
    // When the trial does not subtract its top bit is necessarily zero, so
    // truncating back to WIDTH bits loses nothing.
    always_comb begin
        rem   = acc_i[2*WIDTH-1:WIDTH];
        quo   = acc_i[WIDTH-1:0];
        trial = '0;
        for (int j = 0; j < RADIX_BITS; j++) begin
            trial = {rem, quo[WIDTH-1]};
            if (trial >= {1'b0, divisor_i}) begin
                trial = trial - {1'b0, divisor_i};
                quo   = {quo[WIDTH-2:0], 1'b1};
            end else begin
                quo   = {quo[WIDTH-2:0], 1'b0};
            end
            rem = trial[WIDTH-1:0];
        end
    end

    assign acc_o = is_div_i ? {rem, quo} : mul_acc;

endmodule

// File: rtl/ibex_multdiv_iter.sv
// rtl/ibex_multdiv_iter.sv - iterative RV32M multiplier/divider with valid/ready handshakes
//
// Optional feature macro: IBEX_MULTDIV_EARLY_TERM_EN (early exit for short
// multipliers and for divide by zero; timing becomes data dependent).
//
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   req_valid_i/ready_o   : request handshake; ready only in IDLE
//   operator_i            : MD_OP_MULL/MULH/DIV/REM, sampled on accept
//   signed_mode_i         : [0] op_a signed, [1] op_b signed, sampled on accept
//   op_a_i, op_b_i        : operands, sampled on accept
//   kill_i                : abort any operation in flight
//   resp_valid_o/ready_i  : response handshake; valid only in DONE
//   result_o              : result, held while resp_valid_o is high
module ibex_multdiv_iter
    import ibex_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int RADIX_BITS = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  md_op_e           operator_i,
    input  logic [1:0]       signed_mode_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             kill_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [WIDTH-1:0] result_o
);

    localparam int N     = WIDTH / RADIX_BITS;
    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N - 1);

    md_iter_state_e state_q, state_d;

    md_op_e             op_q;
    logic [1:0]         sign_q;
    logic [WIDTH-1:0]   opa_q;
    logic [WIDTH-1:0]   opb_q;     // raw op_b, then |b|; the multiplier shifts right in ITER
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;   // |a| shifted left one digit per ITER cycle
    logic               neg_q;
    logic               neg_r;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   result_q;

    logic               is_mult;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   fix_result;

    assign is_mult = (op_q == MD_OP_MULL) || (op_q == MD_OP_MULH);

    assign a_neg = sign_q[0] & opa_q[WIDTH-1];
    assign b_neg = sign_q[1] & opb_q[WIDTH-1];
    assign a_mag = a_neg ? -opa_q : opa_q;
    assign b_mag = b_neg ? -opb_q : opb_q;

    ibex_multdiv_iter_step #(
        .WIDTH      (WIDTH),
        .RADIX_BITS (RADIX_BITS)
    ) u_step (
        .is_div_i  (!is_mult),
        .acc_i     (acc_q),
        .mcand_i   (mcand_q),
        .digit_i   (opb_q[RADIX_BITS-1:0]),
        .divisor_i (opb_q),
        .acc_o     (step_acc)
    );

    // Sign fix on the magnitude results.
    always_comb begin
        prod_fix   = neg_q ? -acc_q : acc_q;
        quo        = acc_q[WIDTH-1:0];
        rem        = acc_q[2*WIDTH-1:WIDTH];
        fix_result = '0;
        unique case (op_q)
            MD_OP_MULL: fix_result = prod_fix[WIDTH-1:0];
            MD_OP_MULH: fix_result = prod_fix[2*WIDTH-1:WIDTH];
            MD_OP_DIV:  fix_result = neg_q ? -quo : quo;
            MD_OP_REM:  fix_result = neg_r ? -rem : rem;
            default:    fix_result = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) state_d = PREP;
            end
            PREP: begin
                state_d = ITER;
`ifdef IBEX_MULTDIV_EARLY_TERM_EN
                if (!is_mult && (opb_q == '0)) state_d = DONE;
`endif
            end
            ITER: begin
                if (cnt_q == LAST_ITER) begin
                    state_d = FIXUP;
                end
`ifdef IBEX_MULTDIV_EARLY_TERM_EN
                // Nothing left to add once the shifted-out multiplier is empty.
                else if (is_mult && ((opb_q >> RADIX_BITS) == '0)) begin
                    state_d = FIXUP;
                end
`endif
            end
            FIXUP: state_d = DONE;
            DONE: begin
                if (resp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Kill overrides everything, including a response being consumed.
        if (kill_i && (state_q != IDLE)) state_d = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q     <= MD_OP_MULL;
            sign_q   <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        op_q   <= operator_i;
                        sign_q <= signed_mode_i;
                        opa_q  <= op_a_i;
                        opb_q  <= op_b_i;
                    end
                end
                PREP: begin
                    cnt_q <= '0;
                    opb_q <= b_mag;
                    neg_r <= a_neg;
                    if (is_mult) begin
                        neg_q   <= a_neg ^ b_neg;
                        acc_q   <= '0;
                        mcand_q <= {{WIDTH{1'b0}}, a_mag};
                    end else begin
                        // A zero divisor yields all-ones with no sign fix.
                        neg_q <= (a_neg ^ b_neg) & (opb_q != '0);
                        acc_q <= {{WIDTH{1'b0}}, a_mag};
                    end
`ifdef IBEX_MULTDIV_EARLY_TERM_EN
                    if (!is_mult && (opb_q == '0)) begin
                        result_q <= (op_q == MD_OP_DIV) ? '1 : opa_q;
                    end
`endif
                end
                ITER: begin
                    cnt_q <= cnt_q + 1'b1;
                    acc_q <= step_acc;
                    if (is_mult) begin
                        mcand_q <= mcand_q << RADIX_BITS;
                        opb_q   <= opb_q >> RADIX_BITS;
                    end
                end
                FIXUP: begin
                    result_q <= fix_result;
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = (state_q == DONE);
    assign result_o     = result_q;

endmodule
